// File: rtl/rsa_io_pkg.sv
`timescale 1ns/1ps
// Shared types, constants and the digit legality check for the RSA operand entry path.
package rsa_io_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_BS = 8'h08;

    // The converter's default path can emit X/Z, so those codes are rejected as well.
    function automatic logic nibble_legal(input logic [7:0] code);
        return (code[7:4] == 4'h0) && !$isunknown(code);
    endfunction

endpackage

// File: rtl/hex_operand_collector.sv
`timescale 1ns/1ps
// Shifts decoded hex digits MSB-first into a WIDTH-bit operand and offers it on term.
// Optional macro HEX_OPERAND_BACKSPACE_EN enables the bksp delete-last-digit strobe.
module hex_operand_collector
    import rsa_io_pkg::*;
#(
    parameter  int WIDTH      = 64,
    localparam int MAX_DIGITS = WIDTH / 4,
    localparam int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       nib_in,
    input  logic             nib_valid,
    input  logic             term,
    input  logic             bksp,
    output logic [WIDTH-1:0] operand,
    output logic             operand_valid,
    input  logic             operand_ready,
    output logic [CNT_W-1:0] digit_cnt,
    output logic             busy,
    output logic             bad_char,
    output logic             ovf,
    output state_e           state_dbg
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               bad_q, bad_d;
    logic               ovf_q, ovf_d;
    logic               bksp_hit;

`ifndef HEX_OPERAND_BACKSPACE_EN
    logic bksp_unused;
    assign bksp_unused = bksp;
`endif

    // Handshake: operand_valid rises the cycle after term and holds with operand
    // stable until a cycle with operand_valid && operand_ready; that cycle is the transfer.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        bad_d    = 1'b0;
        ovf_d    = ovf_q;
        bksp_hit = 1'b0;
        case (state_q)
            IDLE, COLLECT: begin
`ifdef HEX_OPERAND_BACKSPACE_EN
                if (bksp && state_q == COLLECT) begin
                    bksp_hit = 1'b1;
                    acc_d    = acc_q >> 4;
                    cnt_d    = cnt_q - CNT_W'(1);
                    ovf_d    = 1'b0;
                    if (cnt_d == '0) begin
                        state_d = IDLE;
                    end
                end
`endif
                if (nib_valid && !bksp_hit) begin
                    if (!nibble_legal(nib_in)) begin
                        bad_d = 1'b1;
                    end else if (cnt_q < MAX_CNT) begin
                        acc_d   = {acc_q[WIDTH-5:0], nib_in[3:0]};
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = COLLECT;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                // term sees the digit count after this cycle's digit/backspace.
                if (term && cnt_d != '0) begin
                    state_d = HOLD;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            HOLD: begin
                if (operand_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            bad_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            bad_q   <= bad_d;
            ovf_q   <= ovf_d;
        end
    end

    assign operand       = acc_q;
    assign operand_valid = valid_q;
    assign digit_cnt     = cnt_q;
    assign busy          = busy_q;
    assign bad_char      = bad_q;
    assign ovf           = ovf_q;
    assign state_dbg     = state_q;

endmodule

// File: doc/hex_operand_collector.md
Name: hex_operand_collector

Overview:
- Sits directly downstream of the ASCII-to-nibble converter in the RSA operand entry path.
- Consumes one decoded hex digit per strobe and shifts the digits MSB-first into a WIDTH-bit operand register.
- On a terminator strobe, presents the completed operand (message, exponent or modulus) to the RSA core over a valid/ready handshake.
- Rejects non-hex codes and flags digit overflow.

Parameters:
- WIDTH, 64, operand width in bits; must be a multiple of 4, minimum 8.
- MAX_DIGITS, WIDTH/4, local constant (not overridable); maximum digits accepted per operand.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- nib_in  in  8  decoded digit from the converter; legal range 8'h00..8'h0F.
- nib_valid  in  1  one-cycle strobe; nib_in is sampled on this cycle. Upstream aligns this strobe with the converter's registered output.
- term  in  1  one-cycle end-of-operand strobe (carriage return detected upstream).
- bksp  in  1  one-cycle delete-last-digit strobe; used only with BACKSPACE_EN, otherwise ignored.
- operand  out  WIDTH  assembled operand, right-justified, zero-extended.
- operand_valid  out  1  operand is stable and offered to the consumer.
- operand_ready  in  1  consumer accepts when operand_valid && operand_ready.
- digit_cnt  out  $clog2(MAX_DIGITS+1)  number of digits held.
- busy  out  1  high in HOLD; new input is ignored.
- bad_char  out  1  one-cycle pulse when a rejected code arrives.
- ovf  out  1  sticky: a digit was dropped because the operand was full.

Behaviour:
- Reset (async, immediate): state=IDLE; acc=0, operand=0, operand_valid=0, digit_cnt=0, busy=0, bad_char=0, ovf=0. Reset mid-collection or mid-HOLD discards everything; no partial handshake survives.
- States: IDLE, COLLECT, HOLD.
- Legal digit: nib_valid=1 and nib_in[7:4]==4'h0 with every bit of nib_in known (0 or 1).
- Digit acceptance (IDLE or COLLECT, legal digit, digit_cnt<MAX_DIGITS):
  - acc <= {acc[WIDTH-5:0], nib_in[3:0]}; digit_cnt++; state=COLLECT.
  - Visible on operand/digit_cnt the cycle after the strobe (1-cycle latency).
- Illegal code (upper nibble nonzero, or any X/Z bit from the converter default path): no shift; bad_char=1 for exactly the next cycle; state unchanged.
- Full (digit_cnt==MAX_DIGITS) and a legal digit arrives: digit dropped; acc unchanged; ovf<=1.
- term in COLLECT: state=HOLD; operand_valid=1 and busy=1 from the next cycle.
- term in IDLE (zero digits): ignored; no empty operand is ever emitted.
- nib_valid and term in the same cycle: the digit is processed first (accepted, dropped or rejected), then the operand is completed including that digit. term with an illegal digit in IDLE still stays in IDLE.
- HOLD:
  - operand and operand_valid are held stable until operand_ready=1.
  - nib_valid, term and bksp are ignored; bad_char is not asserted.
  - On handshake: next cycle operand_valid=0, busy=0, acc=0, digit_cnt=0, ovf=0, state=IDLE. The operand output bus returns to 0.
- operand is driven continuously from acc; the consumer samples it only while operand_valid=1.

Optional Feature:
- Macro: HEX_OPERAND_BACKSPACE_EN.
- Defined:
  - bksp in COLLECT: acc <= acc >> 4; digit_cnt--; ovf cleared. If digit_cnt reaches 0, state=IDLE.
  - bksp in IDLE or HOLD: ignored.
  - bksp and nib_valid in the same cycle: bksp wins; the digit is dropped and bad_char is not raised.
  - bksp and term in the same cycle: backspace applied first; if digits remain, go to HOLD, else stay in IDLE.
- Undefined: the bksp port exists but is ignored; no backspace logic is synthesised.

Decomposition:
- Shared package rsa_io_pkg:
  - state typedef (IDLE/COLLECT/HOLD).
  - ASCII constants: CR 8'h0D, BS 8'h08.
  - Nibble-legal check function.
- No sub-module: a single module holding the FSM and the shift accumulator.

Test Plan:
- Digits 1,2,3,a then term, ready=1 after 3 cycles → operand=64'h123A; valid held 3 cycles; digit_cnt=4 during HOLD; returns to IDLE with digit_cnt=0.
- nib_in=8'hZZ, then 8'h1F, then 8'h05, term → bad_char pulses twice; operand=64'h5.
- 17 digits of f (WIDTH=64), term → operand=64'hFFFF_FFFF_FFFF_FFFF; ovf=1; ovf cleared after handshake.
- Digit 7 with term in the same cycle after digit 3 → operand=64'h37. Bare term in IDLE → operand_valid stays 0.
- Digit 9 strobed during HOLD; rst asserted mid-COLLECT after digits 4,4 → HOLD value unchanged; after reset all outputs=0 asynchronously. Next 1, term → operand=64'h1.
- HEX_OPERAND_BACKSPACE_EN defined: digits a,b,bksp,c, term → operand=64'hAC. With the macro undefined, the same stimulus → operand=64'hABC.
